// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the circular FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 2;

    // Occupancy needs one extra bit so that "full" (count == depth) is representable.
    function automatic int occ_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/circular_fifo_rev2_if.sv
// Producer/consumer handshake, status and debug bundle for circular_fifo_rev2.
interface circular_fifo_rev2_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                              flush;
    logic                              wr_cs;
    logic                              wr_en;
    logic [DATA_WIDTH-1:0]             data_in;
    logic                              rd_cs;
    logic                              rd_en;
    logic [DATA_WIDTH-1:0]             data_out;
    logic                              rd_valid;
    logic                              full;
    logic                              empty;
    logic                              almost_full;
    logic                              almost_empty;
    logic                              overflow;
    logic                              underflow;
    logic [occ_width(ADDR_WIDTH)-1:0]  data_counter_out;
    logic [ADDR_WIDTH-1:0]             wr_pointer_out;
    logic [ADDR_WIDTH-1:0]             rd_pointer_out;

    modport master (
        output flush, wr_cs, wr_en, data_in, rd_cs, rd_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, data_counter_out, wr_pointer_out, rd_pointer_out
    );

    modport slave (
        input  flush, wr_cs, wr_en, data_in, rd_cs, rd_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, data_counter_out, wr_pointer_out, rd_pointer_out
    );

endinterface

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
module fifo_ram_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read-before-write: a same-edge write to raddr is not visible until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/circular_fifo_rev2.sv
// Circular synchronous FIFO controller: pointers, occupancy, flags and error strobes.
module circular_fifo_rev2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int AF_LEVEL   = RAM_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic              clk,
    input  logic              reset,
    circular_fifo_rev2_if.slave bus
);

    localparam int CW     = occ_width(ADDR_WIDTH);
    localparam int STAGES = 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  full;
    logic                  empty;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [STAGES-1:0]     vld_q;
    logic [STAGES:0]       vld_pipe;
    fifo_op_e              op;

    assign full  = (count == CW'(RAM_DEPTH));
    assign empty = (count == '0);

    // A write into a full FIFO is legal when the same-cycle read frees the oldest slot.
    always_comb begin
        wr_req = bus.wr_cs & bus.wr_en;
        rd_req = bus.rd_cs & bus.rd_en;
        rd_acc = rd_req & ~empty & ~bus.flush;
        wr_acc = wr_req & (~full | rd_acc) & ~bus.flush;
        op     = OP_IDLE;
        case ({rd_acc, wr_acc})
            2'b01:   op = OP_WR;
            2'b10:   op = OP_RD;
            2'b11:   op = OP_RW;
            default: op = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= wr_req & full & ~rd_acc & ~bus.flush;
            underflow_q <= rd_req & empty & ~bus.flush;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_acc)
                    rd_ptr <= rd_ptr + 1'b1;
                case (op)
                    OP_WR:   count <= count + CW'(1);
                    OP_RD:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign vld_pipe = {vld_q, rd_acc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_q <= '0;
        else
            vld_q <= vld_pipe[STAGES-1:0];
    end

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (bus.data_out)
    );

    assign bus.rd_valid         = vld_pipe[STAGES];
    assign bus.full             = full;
    assign bus.empty            = empty;
    assign bus.almost_full      = (count >= CW'(AF_LEVEL));
    assign bus.almost_empty     = (count <= CW'(AE_LEVEL));
    assign bus.overflow         = overflow_q;
    assign bus.underflow        = underflow_q;
    assign bus.data_counter_out = count;
    assign bus.wr_pointer_out   = wr_ptr;
    assign bus.rd_pointer_out   = rd_ptr;

endmodule

// File: tb/tb_circular_fifo_rev2.sv
// Directed self-checking bench for circular_fifo_rev2 at default parameters (8-bit, depth 4).
module tb_circular_fifo_rev2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    circular_fifo_rev2_if bus ();

    circular_fifo_rev2 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {full, empty, almost_full, almost_empty}
    function automatic logic [3:0] flags();
        return {bus.full, bus.empty, bus.almost_full, bus.almost_empty};
    endfunction

    task automatic drive_idle();
        bus.flush = 0; bus.wr_cs = 0; bus.wr_en = 0; bus.data_in = '0;
        bus.rd_cs = 0; bus.rd_en = 0;
    endtask

    // Apply one cycle of stimulus, then sample #1 after the rising edge.
    task automatic step(input logic wcs, input logic wen, input logic [7:0] din,
                        input logic rcs, input logic ren, input logic fl);
        bus.wr_cs = wcs; bus.wr_en = wen; bus.data_in = din;
        bus.rd_cs = rcs; bus.rd_en = ren; bus.flush = fl;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic wr(input logic [7:0] d);
        step(1, 1, d, 0, 0, 0);
    endtask

    task automatic rd();
        step(0, 0, 8'h00, 1, 1, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        #3;
        checks++; if (flags() !== 4'b0101) begin errors++; $display("FAIL reset_flags got %b want 0101", flags()); end
        checks++; if ({bus.overflow, bus.underflow, bus.rd_valid} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {bus.overflow, bus.underflow, bus.rd_valid}); end
        checks++; if ({bus.data_counter_out, bus.wr_pointer_out, bus.rd_pointer_out} !== 7'd0) begin errors++; $display("FAIL reset_cnt_ptr got %h want 0", {bus.data_counter_out, bus.wr_pointer_out, bus.rd_pointer_out}); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", bus.data_out); end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_fill();
        logic [3:0] exp_flags [4];
        logic [7:0] d [4];
        exp_flags = '{4'b0001, 4'b0000, 4'b0010, 4'b1010};
        d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            wr(d[i]);
            checks++; if (bus.data_counter_out !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.data_counter_out, i + 1); end
            checks++; if (flags() !== exp_flags[i]) begin errors++; $display("FAIL fill_flags[%0d] got %b want %b", i, flags(), exp_flags[i]); end
        end
        checks++; if (bus.wr_pointer_out !== 2'd0) begin errors++; $display("FAIL fill_wrap_ptr got %0d want 0", bus.wr_pointer_out); end
        wr(8'hEE);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse got %b want 1", bus.overflow); end
        checks++; if (bus.data_counter_out !== 3'd4 || bus.wr_pointer_out !== 2'd0) begin errors++; $display("FAIL overflow_state cnt %0d wp %0d want 4 0", bus.data_counter_out, bus.wr_pointer_out); end
        step(0, 0, 8'h00, 0, 0, 0);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b want 0", bus.overflow); end
    endtask

    task automatic test_drain();
        logic [7:0] d [4];
        d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            rd();
            checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== d[i]) begin errors++; $display("FAIL drain_rd[%0d] got v%b %h want v1 %h", i, bus.rd_valid, bus.data_out, d[i]); end
            checks++; if (bus.data_counter_out !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, bus.data_counter_out, 3 - i); end
            // enable without chip select must not read
            step(0, 0, 8'h00, 0, 1, 0);
            checks++; if (bus.rd_valid !== 1'b0 || bus.data_out !== d[i]) begin errors++; $display("FAIL drain_hold[%0d] got v%b %h want v0 %h", i, bus.rd_valid, bus.data_out, d[i]); end
        end
        checks++; if (flags() !== 4'b0101) begin errors++; $display("FAIL drain_empty got %b want 0101", flags()); end
        rd();
        checks++; if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_pulse got u%b v%b want u1 v0", bus.underflow, bus.rd_valid); end
        checks++; if (bus.data_out !== 8'hDD || bus.data_counter_out !== 3'd0) begin errors++; $display("FAIL underflow_hold got %h cnt %0d want DD 0", bus.data_out, bus.data_counter_out); end
        step(0, 0, 8'h00, 0, 0, 0);
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got %b want 0", bus.underflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] first [3];
        logic [7:0] back  [4];
        first = '{8'hAA, 8'hBB, 8'hCC};
        back  = '{8'hDD, 8'h77, 8'h66, 8'h55};
        wr(8'hAA); wr(8'hBB); wr(8'hCC); wr(8'hDD);
        for (int i = 0; i < 3; i++) begin
            rd();
            checks++; if (bus.data_out !== first[i]) begin errors++; $display("FAIL wrap_pre[%0d] got %h want %h", i, bus.data_out, first[i]); end
        end
        wr(8'h77); wr(8'h66); wr(8'h55);
        checks++; if (bus.wr_pointer_out !== 2'd3 || bus.data_counter_out !== 3'd4 || bus.full !== 1'b1) begin errors++; $display("FAIL wrap_refill wp %0d cnt %0d full %b want 3 4 1", bus.wr_pointer_out, bus.data_counter_out, bus.full); end
        for (int i = 0; i < 4; i++) begin
            rd();
            checks++; if (bus.data_out !== back[i] || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL wrap_rd[%0d] got %h v%b want %h v1", i, bus.data_out, bus.rd_valid, back[i]); end
        end
        checks++; if (bus.data_counter_out !== 3'd0 || bus.rd_pointer_out !== 2'd3 || bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_end cnt %0d rp %0d empty %b want 0 3 1", bus.data_counter_out, bus.rd_pointer_out, bus.empty); end
    endtask

    task automatic test_concurrent();
        logic [7:0] rest [4];
        rest = '{8'h20, 8'h30, 8'h40, 8'h11};
        wr(8'h10); wr(8'h20); wr(8'h30); wr(8'h40);
        step(1, 1, 8'h11, 1, 1, 0);
        checks++; if (bus.data_out !== 8'h10 || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rw_full_rd got %h v%b want 10 v1", bus.data_out, bus.rd_valid); end
        checks++; if (bus.data_counter_out !== 3'd4 || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin errors++; $display("FAIL rw_full_state cnt %0d ovf %b full %b want 4 0 1", bus.data_counter_out, bus.overflow, bus.full); end
        for (int i = 0; i < 4; i++) begin
            rd();
            checks++; if (bus.data_out !== rest[i]) begin errors++; $display("FAIL rw_drain[%0d] got %h want %h", i, bus.data_out, rest[i]); end
        end
        step(1, 1, 8'h22, 1, 1, 0);
        checks++; if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rw_empty_strobe got u%b v%b want u1 v0", bus.underflow, bus.rd_valid); end
        checks++; if (bus.data_counter_out !== 3'd1 || bus.data_out !== 8'h11) begin errors++; $display("FAIL rw_empty_state cnt %0d dout %h want 1 11", bus.data_counter_out, bus.data_out); end
        rd();
        checks++; if (bus.data_out !== 8'h22 || bus.data_counter_out !== 3'd0) begin errors++; $display("FAIL rw_empty_next got %h cnt %0d want 22 0", bus.data_out, bus.data_counter_out); end
    endtask

    task automatic test_flush();
        wr(8'h33); wr(8'h44); wr(8'h55);
        checks++; if (bus.data_counter_out !== 3'd3) begin errors++; $display("FAIL flush_pre cnt %0d want 3", bus.data_counter_out); end
        step(1, 1, 8'h66, 1, 1, 1);
        checks++; if (bus.data_counter_out !== 3'd0 || flags() !== 4'b0101) begin errors++; $display("FAIL flush_count cnt %0d flags %b want 0 0101", bus.data_counter_out, flags()); end
        checks++; if (bus.wr_pointer_out !== 2'd0 || bus.rd_pointer_out !== 2'd0) begin errors++; $display("FAIL flush_ptrs got %0d %0d want 0 0", bus.wr_pointer_out, bus.rd_pointer_out); end
        checks++; if ({bus.overflow, bus.underflow, bus.rd_valid} !== 3'b000 || bus.data_out !== 8'h22) begin errors++; $display("FAIL flush_quiet got %b dout %h want 000 22", {bus.overflow, bus.underflow, bus.rd_valid}, bus.data_out); end
        wr(8'h77);
        rd();
        checks++; if (bus.data_out !== 8'h77 || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL flush_after got %h v%b want 77 v1", bus.data_out, bus.rd_valid); end
    endtask

    task automatic test_reset_mid();
        wr(8'h01); wr(8'h02);
        rd();
        checks++; if (bus.data_out !== 8'h01 || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %h v%b want 01 v1", bus.data_out, bus.rd_valid); end
        bus.wr_cs = 1; bus.wr_en = 1; bus.data_in = 8'h03;
        reset = 1'b0;
        #2;
        checks++; if (flags() !== 4'b0101 || {bus.overflow, bus.underflow, bus.rd_valid} !== 3'b000) begin errors++; $display("FAIL mid_async_flags got %b %b want 0101 000", flags(), {bus.overflow, bus.underflow, bus.rd_valid}); end
        checks++; if ({bus.data_counter_out, bus.wr_pointer_out, bus.rd_pointer_out} !== 7'd0 || bus.data_out !== 8'h00) begin errors++; $display("FAIL mid_async_state got %h dout %h want 0 00", {bus.data_counter_out, bus.wr_pointer_out, bus.rd_pointer_out}, bus.data_out); end
        @(posedge clk);
        #1;
        checks++; if (bus.data_counter_out !== 3'd0) begin errors++; $display("FAIL mid_held cnt %0d want 0", bus.data_counter_out); end
        drive_idle();
        reset = 1'b1;
        wr(8'h5A);
        checks++; if (bus.data_counter_out !== 3'd1 || bus.wr_pointer_out !== 2'd1) begin errors++; $display("FAIL post_reset_wr cnt %0d wp %0d want 1 1", bus.data_counter_out, bus.wr_pointer_out); end
        rd();
        checks++; if (bus.data_out !== 8'h5A || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL post_reset_rd got %h v%b want 5A v1", bus.data_out, bus.rd_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_concurrent();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/circular_fifo_rev2.md
Name: circular_fifo_rev2

Overview:
Parametrised circular synchronous FIFO. It succeeds the non-circular FIFO and keeps that block's chip-select/enable handshake and debug outputs. New over the previous generation: pointer wrap-around, concurrent read/write, almost-full/almost-empty thresholds, overflow/underflow strobes, synchronous flush, and a registered read-valid. It sits between the data producer and consumer blocks, in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of the data word
ADDR_WIDTH, 2, pointer width; depth = RAM_DEPTH
RAM_DEPTH, 1 << ADDR_WIDTH, storage entries; must equal 2**ADDR_WIDTH
AF_LEVEL, RAM_DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
flush  in  1  synchronous clear of pointers and count
wr_cs  in  1  write chip select
wr_en  in  1  write enable; write request = wr_cs & wr_en
data_in  in  DATA_WIDTH  write data
rd_cs  in  1  read chip select
rd_en  in  1  read enable; read request = rd_cs & rd_en
data_out  out  DATA_WIDTH  registered read data
rd_valid  out  1  one-cycle pulse: data_out updated this cycle
full  out  1  count == RAM_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
overflow  out  1  one-cycle pulse: write request rejected
underflow  out  1  one-cycle pulse: read request rejected
data_counter_out  out  ADDR_WIDTH+1  current occupancy
wr_pointer_out  out  ADDR_WIDTH  next write address
rd_pointer_out  out  ADDR_WIDTH  next read address

Behaviour:
- Reset (reset=0, async): pointers=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Flags follow the count: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0). RAM contents are not reset.
- Write accepted when the write request is high and (!full or the read is accepted in the same cycle). The word is stored at wr_pointer; wr_pointer increments modulo RAM_DEPTH, wrapping from RAM_DEPTH-1 to 0.
- Read accepted when the read request is high and !empty. On the next edge, data_out = mem[rd_pointer] and rd_valid=1; rd_pointer increments modulo RAM_DEPTH. Latency: request at edge N, data at edge N+1 output. When no read is accepted, data_out holds its value and rd_valid=0.
- Concurrent read and write:
  - Not empty: both accepted, count unchanged.
  - Full: both accepted. The read returns the oldest word; the write takes the freed slot. No overflow.
  - Empty: write accepted, read rejected with underflow=1. There is no fall-through; the word is readable next cycle.
- Write request while full without an accepted read: no state change, overflow=1 for one cycle.
- Read request while empty: no state change, underflow=1 for one cycle. data_out holds.
- Count: +1 on write only, -1 on read only, unchanged otherwise. Never exceeds RAM_DEPTH and never goes below 0.
- All flags are combinational decodes of the registered count, so they are valid the same cycle the count updates.
- flush=1: on the next edge, pointers=0, count=0, rd_valid=0. Any read/write in that cycle is ignored and raises no error strobes. data_out holds. flush has priority over all requests.
- Reset asserted mid-operation clears state immediately. After reset is released, the first edge behaves as from empty.

Decomposition:
- Shared package fifo_pkg: default DATA_WIDTH/ADDR_WIDTH constants and a function computing occupancy width (ADDR_WIDTH+1).
- Sub-module fifo_ram_dp: simple dual-port RAM with synchronous write and registered synchronous read, DATA_WIDTH x RAM_DEPTH. The FIFO controller holds the pointers, count, flags and strobes.

Test Plan:
- Defaults (8-bit, depth 4). Write AA, BB, CC, DD -> full=1, almost_full=1 from count 3, count=4, wr_pointer=0 (wrapped). A 5th write of EE -> overflow pulse; count stays 4; EE is not stored.
- Read 4 times in the non-consecutive cs toggling pattern -> data_out sequence AA, BB, CC, DD, each with a rd_valid pulse one cycle after its request; empty=1 after the 4th. A 5th read -> underflow pulse, data_out holds DD.
- Wrap test: write 77, 66, 55 after 3 reads of a full FIFO; pointers wrap past 3. Read back -> DD, 77, 66, 55 in order; count returns to 0.
- Full and simultaneous read+write of 11 -> read returns the oldest word, count stays 4, no overflow. Empty and simultaneous read+write of 22 -> underflow=1, count=1, next read returns 22.
- Load 3 words, then pulse flush together with a write request -> count=0, empty=1, pointers=0, no overflow. Assert reset low mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.
